// File: rtl/dc_router_param.sv
// Data/control router between shared RAM and NUM_CH accelerator FIFO pairs.
// Loads filesize words RAM->channel, then drains the same count channel->RAM.
module dc_router_param #(
   parameter int NUM_CH = 3,
   parameter int SEL_W  = 2,
   parameter int DW     = 32,
   parameter int AW     = 32,
   parameter int LEN_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SEL_W-1:0]     instruction,
   input  logic [AW-1:0]        offset,
   input  logic [LEN_W-1:0]     filesize,
   output logic                 acc_done,
   output logic                 sel_err,
   output logic [NUM_CH-1:0]    ch_enable,
   output logic [NUM_CH-1:0]    ch_put_req,
   output logic [DW-1:0]        ch_wdata,
   input  logic [NUM_CH-1:0]    to_full,
   output logic [NUM_CH-1:0]    ch_get_req,
   input  logic [NUM_CH*DW-1:0] ch_rdata,
   input  logic [NUM_CH-1:0]    from_empty,
   output logic                 ram_read_enable,
   output logic                 ram_write_enable,
   output logic [AW-1:0]        addr,
   input  logic [DW-1:0]        ram_rdata,
   output logic [DW-1:0]        ram_wdata
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SEL_W-1:0]  NUM_CH_S = SEL_W'(NUM_CH);
   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   typedef enum logic [2:0] {IDLE, LD_RD, LD_PUT, DR_GET, DR_WR, DONE} state_t;

   state_t            r_state;
   logic [CH_W-1:0]   r_ch;
   logic [AW-1:0]     r_offset;
   logic [LEN_W-1:0]  r_size;
   logic [LEN_W-1:0]  r_rd_cnt;
   logic [LEN_W-1:0]  r_wr_cnt;
   logic [DW-1:0]     r_hold;
   logic              r_ld_first;

   logic              w_go;
   logic              w_valid_sel;
   logic              w_full;
   logic              w_empty;
   logic [DW-1:0]     w_rdata;
   logic [NUM_CH-1:0] w_onehot;
   logic              w_rd_fire;
   logic              w_put_fire;
   logic              w_get_fire;
   logic              w_wr_fire;
   logic [DW-1:0]     w_put_data;
   logic [LEN_W-1:0]  w_rd_next;
   logic [LEN_W-1:0]  w_wr_next;

   assign w_go        = (instruction != '0);
   assign w_valid_sel = w_go && (instruction <= NUM_CH_S);
   assign w_onehot    = ONE_HOT0 << r_ch;
   assign w_rd_next   = r_rd_cnt + LEN_W'(1);
   assign w_wr_next   = r_wr_cnt + LEN_W'(1);

   // Select the latched channel's status and result data
   always_comb begin
      w_full  = 1'b0;
      w_empty = 1'b0;
      w_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_full  = (r_ch == CH_W'(c)) ? to_full[c]          : w_full;
         w_empty = (r_ch == CH_W'(c)) ? from_empty[c]       : w_empty;
         w_rdata = (r_ch == CH_W'(c)) ? ch_rdata[c*DW +: DW] : w_rdata;
      end
   end

   // RAM data is only valid in the first LD_PUT cycle; afterwards the hold copy is used
   assign w_put_data = r_ld_first ? ram_rdata : r_hold;

   // Strobes are suppressed in an abort cycle (instruction==0)
   assign w_rd_fire  = (r_state == LD_RD)  && w_go && !w_full;
   assign w_put_fire = (r_state == LD_PUT) && w_go && !w_full;
   assign w_get_fire = (r_state == DR_GET) && w_go && !w_empty;
   assign w_wr_fire  = (r_state == DR_WR)  && w_go;

   assign ch_enable        = (r_state != IDLE) ? w_onehot : '0;
   assign acc_done         = (r_state == DONE);
   assign sel_err          = (r_state == IDLE) && (instruction > NUM_CH_S);
   assign ch_put_req       = w_put_fire ? w_onehot : '0;
   assign ch_get_req       = w_get_fire ? w_onehot : '0;
   assign ch_wdata         = (r_state == LD_PUT) ? w_put_data : '0;
   assign ram_read_enable  = w_rd_fire;
   assign ram_write_enable = w_wr_fire;
   assign ram_wdata        = w_wr_fire ? w_rdata : '0;
   assign addr             = w_rd_fire ? (r_offset + AW'(r_rd_cnt)) :
                             w_wr_fire ? (r_offset + AW'(r_wr_cnt)) : '0;

   // Job sequencer and latched job parameters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_ch       <= '0;
         r_offset   <= '0;
         r_size     <= '0;
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_hold     <= '0;
         r_ld_first <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid_sel) begin
                  r_ch     <= CH_W'(instruction - SEL_W'(1));
                  r_offset <= offset;
                  r_size   <= filesize;
                  r_rd_cnt <= '0;
                  r_wr_cnt <= '0;
                  r_state  <= (filesize == '0) ? DONE : LD_RD;
               end else begin
                  r_state <= IDLE;
               end
            end
            LD_RD: begin
               if (!w_go) begin
                  r_state <= IDLE;
               end else if (!w_full) begin
                  r_state    <= LD_PUT;
                  r_ld_first <= 1'b1;
               end else begin
                  r_state <= LD_RD;
               end
            end
            LD_PUT: begin
               r_ld_first <= 1'b0;
               if (!w_go) begin
                  r_state <= IDLE;
               end else begin
                  if (r_ld_first) begin
                     r_hold <= ram_rdata;
                  end else begin
                     r_hold <= r_hold;
                  end
                  if (!w_full) begin
                     r_rd_cnt <= w_rd_next;
                     r_state  <= (w_rd_next == r_size) ? DR_GET : LD_RD;
                  end else begin
                     r_state <= LD_PUT;
                  end
               end
            end
            DR_GET: begin
               if (!w_go) begin
                  r_state <= IDLE;
               end else if (!w_empty) begin
                  r_state <= DR_WR;
               end else begin
                  r_state <= DR_GET;
               end
            end
            DR_WR: begin
               if (!w_go) begin
                  r_state <= IDLE;
               end else begin
                  r_wr_cnt <= w_wr_next;
                  r_state  <= (w_wr_next == r_size) ? DONE : DR_GET;
               end
            end
            DONE: begin
               if (!w_go) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dc_router_param.sv
// Directed bench for dc_router_param: a 3-channel instance and a 2-channel instance.
module tb_dc_router_param;

   localparam logic [31:0] CH0_D = 32'hC0C0_0000;
   localparam logic [31:0] CH1_D = 32'hC1C1_1111;
   localparam logic [31:0] CH2_D = 32'hC2C2_2222;

   logic        clk;
   logic        reset;
   int          n_tests;
   int          n_fail;

   logic [1:0]  instruction;
   logic [31:0] offset;
   logic [15:0] filesize;
   logic        acc_done, sel_err;
   logic [2:0]  ch_enable, ch_put_req, ch_get_req, to_full, from_empty;
   logic [31:0] ch_wdata, addr, ram_rdata, ram_wdata;
   logic [95:0] ch_rdata;
   logic        ram_read_enable, ram_write_enable;

   logic [1:0]  b_instruction;
   logic [31:0] b_offset;
   logic [15:0] b_filesize;
   logic        b_acc_done, b_sel_err;
   logic [1:0]  b_ch_enable, b_ch_put_req, b_ch_get_req, b_to_full, b_from_empty;
   logic [31:0] b_ch_wdata, b_addr, b_ram_rdata, b_ram_wdata;
   logic [63:0] b_ch_rdata;
   logic        b_ram_read_enable, b_ram_write_enable;

   dc_router_param #(.NUM_CH(3), .SEL_W(2), .DW(32), .AW(32), .LEN_W(16)) u_dut (
      .clk(clk), .reset(reset), .instruction(instruction), .offset(offset), .filesize(filesize),
      .acc_done(acc_done), .sel_err(sel_err), .ch_enable(ch_enable), .ch_put_req(ch_put_req),
      .ch_wdata(ch_wdata), .to_full(to_full), .ch_get_req(ch_get_req), .ch_rdata(ch_rdata),
      .from_empty(from_empty), .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
      .addr(addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata));

   dc_router_param #(.NUM_CH(2), .SEL_W(2), .DW(32), .AW(32), .LEN_W(16)) u_dut2 (
      .clk(clk), .reset(reset), .instruction(b_instruction), .offset(b_offset), .filesize(b_filesize),
      .acc_done(b_acc_done), .sel_err(b_sel_err), .ch_enable(b_ch_enable), .ch_put_req(b_ch_put_req),
      .ch_wdata(b_ch_wdata), .to_full(b_to_full), .ch_get_req(b_ch_get_req), .ch_rdata(b_ch_rdata),
      .from_empty(b_from_empty), .ram_read_enable(b_ram_read_enable), .ram_write_enable(b_ram_write_enable),
      .addr(b_addr), .ram_rdata(b_ram_rdata), .ram_wdata(b_ram_wdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then settled from the new state
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b0;
      instruction = 2'd0; offset = 32'd0; filesize = 16'd0;
      to_full = 3'b000; from_empty = 3'b000; ram_rdata = 32'd0;
      ch_rdata = {CH2_D, CH1_D, CH0_D};
      b_instruction = 2'd0; b_offset = 32'd0; b_filesize = 16'd0;
      b_to_full = 2'b00; b_from_empty = 2'b00; b_ram_rdata = 32'd0;
      b_ch_rdata = {CH1_D, CH0_D};
      #3;
      chk("rst_enable", {61'd0, ch_enable}, 64'd0);
      chk("rst_done", {63'd0, acc_done}, 64'd0);
      chk("rst_addr", {32'd0, addr}, 64'd0);
      step(); step();
      reset = 1'b1;
      step();

      // Test 1: asynchronous reset in the middle of LD_PUT
      instruction = 2'd1; offset = 32'd100; filesize = 16'd4; ram_rdata = 32'd122;
      step(); step();
      chk("t1_put_before_rst", {61'd0, ch_put_req}, 64'h1);
      reset = 1'b0;
      #1;
      chk("t1_put_rst", {61'd0, ch_put_req}, 64'd0);
      chk("t1_en_rst", {61'd0, ch_enable}, 64'd0);
      chk("t1_wdata_rst", {32'd0, ch_wdata}, 64'd0);
      chk("t1_addr_rst", {32'd0, addr}, 64'd0);
      instruction = 2'd0;
      step();
      reset = 1'b1;
      step();
      chk("t1_idle_en", {61'd0, ch_enable}, 64'd0);
      chk("t1_idle_re", {63'd0, ram_read_enable}, 64'd0);

      // Test 2: full job on channel 0; unselected channels report full/empty
      instruction = 2'd1; offset = 32'd100; filesize = 16'd4; ram_rdata = 32'd122;
      to_full = 3'b110; from_empty = 3'b110;
      #1;
      chk("t2_sel_cycle_en", {61'd0, ch_enable}, 64'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("t2_rd_en", {63'd0, ram_read_enable}, 64'd1);
         chk("t2_rd_addr", {32'd0, addr}, 64'(100 + i));
         chk("t2_rd_nop_put", {61'd0, ch_put_req}, 64'd0);
         chk("t2_rd_enable", {61'd0, ch_enable}, 64'h1);
         step();
         chk("t2_put", {61'd0, ch_put_req}, 64'h1);
         chk("t2_put_data", {32'd0, ch_wdata}, 64'd122);
         chk("t2_put_nore", {63'd0, ram_read_enable}, 64'd0);
         step();
      end
      for (int j = 0; j < 4; j++) begin
         chk("t2_get", {61'd0, ch_get_req}, 64'h1);
         chk("t2_get_nowe", {63'd0, ram_write_enable}, 64'd0);
         step();
         chk("t2_wr_en", {63'd0, ram_write_enable}, 64'd1);
         chk("t2_wr_addr", {32'd0, addr}, 64'(100 + j));
         chk("t2_wr_data", {32'd0, ram_wdata}, {32'd0, CH0_D});
         chk("t2_wr_notdone", {63'd0, acc_done}, 64'd0);
         step();
      end
      chk("t2_done_at_17", {63'd0, acc_done}, 64'd1);
      chk("t2_done_enable", {61'd0, ch_enable}, 64'h1);
      instruction = 2'd0;
      #1;
      chk("t2_done_hold", {63'd0, acc_done}, 64'd1);
      step();
      chk("t2_done_clear", {63'd0, acc_done}, 64'd0);
      chk("t2_idle_en", {61'd0, ch_enable}, 64'd0);
      to_full = 3'b000; from_empty = 3'b000;

      // Test 3: channel 2 with input-full and output-empty stalls
      instruction = 2'd3; offset = 32'd200; filesize = 16'd2; ram_rdata = 32'h33;
      step();
      chk("t3_rd_addr", {32'd0, addr}, 64'd200);
      chk("t3_enable", {61'd0, ch_enable}, 64'h4);
      step();
      to_full = 3'b100;
      #1;
      chk("t3_stall_first", {61'd0, ch_put_req}, 64'd0);
      chk("t3_stall_first_data", {32'd0, ch_wdata}, 64'h33);
      step();
      ram_rdata = 32'hBAD;
      for (int k = 0; k < 4; k++) begin
         chk("t3_stall_put", {61'd0, ch_put_req}, 64'd0);
         chk("t3_stall_hold", {32'd0, ch_wdata}, 64'h33);
         step();
      end
      to_full = 3'b000;
      #1;
      chk("t3_put_release", {61'd0, ch_put_req}, 64'h4);
      chk("t3_put_data", {32'd0, ch_wdata}, 64'h33);
      step();
      ram_rdata = 32'h44;
      chk("t3_rd2_addr", {32'd0, addr}, 64'd201);
      step();
      chk("t3_put2_data", {32'd0, ch_wdata}, 64'h44);
      step();
      from_empty = 3'b100;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_empty_get", {61'd0, ch_get_req}, 64'd0);
         chk("t3_empty_we", {63'd0, ram_write_enable}, 64'd0);
         step();
      end
      from_empty = 3'b000;
      #1;
      chk("t3_get_release", {61'd0, ch_get_req}, 64'h4);
      step();
      chk("t3_wr0_addr", {32'd0, addr}, 64'd200);
      chk("t3_wr0_data", {32'd0, ram_wdata}, {32'd0, CH2_D});
      step(); step();
      chk("t3_wr1_addr", {32'd0, addr}, 64'd201);
      step();
      chk("t3_done", {63'd0, acc_done}, 64'd1);
      instruction = 2'd0;
      step();

      // Test 4: zero-length job
      instruction = 2'd2; offset = 32'd50; filesize = 16'd0;
      step();
      chk("t4_done", {63'd0, acc_done}, 64'd1);
      chk("t4_enable", {61'd0, ch_enable}, 64'h2);
      chk("t4_no_strobe", {60'd0, ram_read_enable, ram_write_enable, |ch_put_req, |ch_get_req}, 64'd0);
      step();
      chk("t4_done_hold", {63'd0, acc_done}, 64'd1);
      instruction = 2'd0;
      #1;
      chk("t4_done_same_cycle", {63'd0, acc_done}, 64'd1);
      step();
      chk("t4_done_clear", {63'd0, acc_done}, 64'd0);

      // Test 5: abort after three words, mid-job select change ignored, restart
      instruction = 2'd2; offset = 32'd300; filesize = 16'd8; ram_rdata = 32'h55;
      step(); step();
      instruction = 2'd3;
      step();
      chk("t5_ignore_change_en", {61'd0, ch_enable}, 64'h2);
      chk("t5_ignore_change_addr", {32'd0, addr}, 64'd301);
      instruction = 2'd2;
      step(); step(); step(); step();
      chk("t5_rd3_addr", {32'd0, addr}, 64'd303);
      instruction = 2'd0;
      #1;
      chk("t5_abort_no_re", {63'd0, ram_read_enable}, 64'd0);
      step();
      chk("t5_abort_en", {61'd0, ch_enable}, 64'd0);
      chk("t5_abort_done", {63'd0, acc_done}, 64'd0);
      instruction = 2'd2;
      step();
      chk("t5_restart_addr", {32'd0, addr}, 64'd300);
      instruction = 2'd0;
      step();

      // Test 6: bad select and address wrap on the 2-channel instance
      b_instruction = 2'd3;
      #1;
      chk("t6_sel_err", {63'd0, b_sel_err}, 64'd1);
      step();
      chk("t6_sel_err_hold", {63'd0, b_sel_err}, 64'd1);
      chk("t6_sel_en", {62'd0, b_ch_enable}, 64'd0);
      chk("t6_sel_no_strobe", {61'd0, b_ram_read_enable, |b_ch_put_req, |b_ch_get_req}, 64'd0);
      b_instruction = 2'd0;
      #1;
      chk("t6_sel_err_clear", {63'd0, b_sel_err}, 64'd0);
      b_instruction = 2'd1; b_offset = 32'hFFFF_FFFF; b_filesize = 16'd2;
      step();
      chk("t6_addr_top", {32'd0, b_addr}, 64'hFFFF_FFFF);
      step(); step();
      chk("t6_addr_wrap", {32'd0, b_addr}, 64'd0);
      b_instruction = 2'd0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
